// File: rtl/ps2_lcd_pkg.sv
// Shared types, scancode constants and helper functions for the PS/2 to LCD
// character-memory writer.
package ps2_lcd_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_STOP = 2'd2
  } rx_state_e;

  // Decode / write states of the top-level sequencer
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_WRITE  = 2'd2,
    ST_BKSP   = 2'd3
  } state_e;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BKSP   = 8'h66;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] LCD_SPACE  = 8'h20;
  localparam logic       RS_DATA    = 1'b1;

  // Odd parity over data bits plus parity bit: the XOR of all nine must be 1
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  // Scancode set 2 make-code to ASCII; returns {valid, ascii}.
  // Letters come out uppercase when 'upper' is set, otherwise lowercase.
  function automatic logic [8:0] scancode_to_ascii(input logic [7:0] code,
                                                   input logic       upper);
    logic       valid;
    logic       letter;
    logic [7:0] ascii;
    valid  = 1'b1;
    letter = 1'b1;
    ascii  = 8'h00;
    case (code)
      8'h1C: ascii = 8'h41;
      8'h32: ascii = 8'h42;
      8'h21: ascii = 8'h43;
      8'h23: ascii = 8'h44;
      8'h24: ascii = 8'h45;
      8'h2B: ascii = 8'h46;
      8'h34: ascii = 8'h47;
      8'h33: ascii = 8'h48;
      8'h43: ascii = 8'h49;
      8'h3B: ascii = 8'h4A;
      8'h42: ascii = 8'h4B;
      8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D;
      8'h31: ascii = 8'h4E;
      8'h44: ascii = 8'h4F;
      8'h4D: ascii = 8'h50;
      8'h15: ascii = 8'h51;
      8'h2D: ascii = 8'h52;
      8'h1B: ascii = 8'h53;
      8'h2C: ascii = 8'h54;
      8'h3C: ascii = 8'h55;
      8'h2A: ascii = 8'h56;
      8'h1D: ascii = 8'h57;
      8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59;
      8'h1A: ascii = 8'h5A;
      8'h45: begin ascii = 8'h30; letter = 1'b0; end
      8'h16: begin ascii = 8'h31; letter = 1'b0; end
      8'h1E: begin ascii = 8'h32; letter = 1'b0; end
      8'h26: begin ascii = 8'h33; letter = 1'b0; end
      8'h25: begin ascii = 8'h34; letter = 1'b0; end
      8'h2E: begin ascii = 8'h35; letter = 1'b0; end
      8'h36: begin ascii = 8'h36; letter = 1'b0; end
      8'h3D: begin ascii = 8'h37; letter = 1'b0; end
      8'h3E: begin ascii = 8'h38; letter = 1'b0; end
      8'h46: begin ascii = 8'h39; letter = 1'b0; end
      8'h29: begin ascii = LCD_SPACE; letter = 1'b0; end
      default: begin valid = 1'b0; letter = 1'b0; end
    endcase
    if (letter && !upper) begin
      ascii = ascii | 8'h20;
    end else begin
      ascii = ascii;
    end
    return {valid, ascii};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the keyboard lines, detects falling
// clock edges, shifts in start/8 data/parity/stop, checks the frame and
// abandons a partial frame after TIMEOUT_CYCLES without a falling edge.
module ps2_rx_frame
  import ps2_lcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       code_valid_o,
  output logic [7:0] code_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_ZERO = CW'(0);
  localparam logic [CW-1:0] TMO_ONE  = CW'(1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q;
  logic          clk_prev_q;
  logic [1:0]    data_sync_q;
  rx_state_e     state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          frame_err_q, frame_err_d;
  logic          valid_s;
  logic          fall_s;
  logic          bit_s;

  assign fall_s = clk_prev_q & ~clk_sync_q[1];
  assign bit_s  = data_sync_q[1];

  // Two-flop synchronisers (idle-high preset) plus history flop for edge detect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      clk_prev_q  <= 1'b1;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      clk_prev_q  <= clk_sync_q[1];
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  // Frame state, shift register, bit counter, timeout counter and error pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 9'd0;
      tmo_q       <= TMO_ZERO;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic; the timeout counter counts the edge cycle itself,
  // so it reaches TIMEOUT_CYCLES exactly that many cycles after the edge
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    valid_s     = 1'b0;
    case (state_q)
      RX_IDLE: begin
        tmo_d = TMO_ZERO;
        if (fall_s) begin
          if (!bit_s) begin
            state_d   = RX_RECV;
            bit_cnt_d = 4'd0;
            tmo_d     = TMO_ONE;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_RECV: begin
        if (fall_s) begin
          tmo_d     = TMO_ONE;
          shift_d   = {bit_s, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) begin
            state_d = RX_STOP;
          end else begin
            state_d = RX_RECV;
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          state_d     = RX_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      RX_STOP: begin
        if (fall_s) begin
          state_d = RX_IDLE;
          if (bit_s && odd_parity_ok(shift_q)) begin
            valid_s = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          frame_err_d = 1'b1;
          state_d     = RX_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign code_valid_o = valid_s;
  assign code_o       = shift_q[7:0];
  assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_lcd_writer.sv
// PS/2 keyboard to LCD character-memory writer. Decodes make-codes, tracks
// break prefixes and a wrapping cursor, and issues single-cycle writes.
// Optional build macro KBD_SHIFT_EN: track shift keys and emit lowercase
// letters unless shift is held.
module ps2_lcd_writer
  import ps2_lcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int NUM_CELLS      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [8:0] wr_data,
  output logic [5:0] cursor,
  output logic       frame_err
);

  localparam logic [5:0] LAST_CELL = 6'(NUM_CELLS - 1);

  logic       code_valid_s;
  logic [7:0] rx_code_s;
  logic       upper_s;
  logic [8:0] lookup_s;

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic       break_q, break_d;
  logic [5:0] cursor_q, cursor_d;
  logic       wr_en_q, wr_en_d;
  logic [5:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;

`ifdef KBD_SHIFT_EN
  logic shift_held_q, shift_held_d;
  logic is_shift_s;
  assign upper_s    = shift_held_q;
  assign is_shift_s = (code_q == PS2_LSHIFT) || (code_q == PS2_RSHIFT);

  // Shift-held flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_held_q <= 1'b0;
    end else begin
      shift_held_q <= shift_held_d;
    end
  end
`else
  assign upper_s = 1'b1;
`endif

  assign lookup_s = scancode_to_ascii(code_q, upper_s);

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i        (clk),
    .rst_ni       (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .code_valid_o (code_valid_s),
    .code_o       (rx_code_s),
    .frame_err_o  (frame_err)
  );

  // Sequencer state, captured code, break flag, cursor and write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      code_q    <= 8'h00;
      break_q   <= 1'b0;
      cursor_q  <= 6'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 6'd0;
      wr_data_q <= 9'd0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      break_q   <= break_d;
      cursor_q  <= cursor_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Decode the received code; write strobe is registered on entry to
  // WRITE/BKSP so it is high during that one-cycle state
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    break_d   = break_q;
    cursor_d  = cursor_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef KBD_SHIFT_EN
    shift_held_d = shift_held_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (code_valid_s) begin
          code_d  = rx_code_s;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (code_q == PS2_BREAK) begin
          break_d = 1'b1;
        end else if (code_q == PS2_EXT) begin
          break_d = break_q;
        end else if (break_q) begin
          break_d = 1'b0;
`ifdef KBD_SHIFT_EN
          if (is_shift_s) begin
            shift_held_d = 1'b0;
          end else begin
            shift_held_d = shift_held_q;
          end
        end else if (is_shift_s) begin
          shift_held_d = 1'b1;
`endif
        end else if (code_q == PS2_BKSP) begin
          state_d = ST_BKSP;
          if (cursor_q != 6'd0) begin
            cursor_d  = cursor_q - 6'd1;
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_q - 6'd1;
            wr_data_d = {RS_DATA, LCD_SPACE};
          end else begin
            cursor_d = 6'd0;
          end
        end else if (lookup_s[8]) begin
          state_d   = ST_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = cursor_q;
          wr_data_d = {RS_DATA, lookup_s[7:0]};
          if (cursor_q == LAST_CELL) begin
            cursor_d = 6'd0;
          end else begin
            cursor_d = cursor_q + 6'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_BKSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign cursor  = cursor_q;

endmodule

// File: doc/ps2_lcd_writer.md
Name: ps2_lcd_writer

Overview:
- Write side of the LCD character memory: receives PS/2 keyboard frames and decodes make-codes to LCD character codes.
- Issues single-cycle writes into the display memory write port (wr_addr/wr_en/wr_data) that the LCD controller reads.
- Maintains a 32-position cursor: line 1 = addresses 0-15, line 2 = addresses 16-31.

Parameters:
- TIMEOUT_CYCLES, 50000, clk cycles without a PS/2 falling edge mid-frame before the partial frame is discarded (1 ms at 50 MHz).
- NUM_CELLS, 32, number of display cells; cursor range 0..NUM_CELLS-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock from keyboard; asynchronous to clk.
- ps2_data  input  1  raw PS/2 data from keyboard; asynchronous to clk.
- wr_en  output  1  one-cycle write strobe to display memory.
- wr_addr  output  6  cell address 0..31.
- wr_data  output  9  bit8 = RS (1 = character data), bits7:0 = ASCII code.
- cursor  output  6  current cursor position.
- frame_err  output  1  one-cycle pulse on parity/stop/start error or timeout.

Behaviour:
- Reset (rst low, async): wr_en=0, wr_addr=0, wr_data=0, cursor=0, frame_err=0, break flag clear, FSM=IDLE, synchronisers preset to 1.
- Synchronisation: ps2_clk and ps2_data pass through 2-flop synchronisers. A falling edge is sync_clk previous=1, current=0. Data is sampled on that edge.
- FSM states:
  - IDLE: on falling edge with data=0 (start bit) -> RECV, bit count=0. A start bit of 1 pulses frame_err and stays in IDLE.
  - RECV: shift 8 data bits LSB first, then the parity bit; after bit 9 -> STOP.
  - STOP: on next falling edge, require stop=1 and odd parity over data+parity. Pass -> DECODE. Fail -> frame_err pulse, IDLE.
  - DECODE (1 cycle):
    - code 0xF0: set break flag, no write.
    - code 0xE0: ignored, no write.
    - break flag set: clear it, discard code, no write.
    - otherwise look up the code. Printable -> WRITE. Backspace 0x66 -> BKSP. Unmapped -> IDLE.
  - WRITE (1 cycle): wr_en=1, wr_addr=cursor, wr_data={1'b1, ascii}. Cursor increments; 31 wraps to 0. -> IDLE.
  - BKSP (1 cycle):
    - cursor>0: cursor decrements; write {1'b1, 8'h20} at the new cursor.
    - cursor=0: no write, cursor stays 0.
    - -> IDLE.
- Latency: wr_en asserts 2 clk cycles after the stop-bit falling edge is detected through the synchronisers.
- wr_addr and wr_data hold their last value when wr_en=0.
- Timeout: in RECV or STOP, a counter increments every clk and clears on each falling edge. Reaching TIMEOUT_CYCLES pulses frame_err and returns to IDLE. The break flag is kept.
- Map: letters 0x1C,0x32,0x21,... -> 'A'..'Z' (0x41-0x5A); digits 0x45,0x16..0x46 -> '0'..'9'; space 0x29 -> 0x20.
- Reset mid-frame: all state is cleared immediately; the partial frame is lost; no write.

Optional Feature:
- Macro: KBD_SHIFT_EN.
- Defined:
  - Tracks left/right shift make/break (0x12, 0x59) in a shift_held flag.
  - Letters are emitted lowercase (0x61-0x7A) unless shift_held, then uppercase.
  - Shift make/break never writes.
- Undefined:
  - Shift codes are unmapped (no write).
  - Letters are always uppercase.

Decomposition:
- Package ps2_lcd_pkg:
  - state enum.
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0, PS2_BKSP=8'h66, PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59, LCD_SPACE=8'h20, RS_DATA=1'b1.
  - function scancode_to_ascii returning {valid, ascii}.
- One sub-module, ps2_rx_frame: synchronisers, edge detect, shift register, parity/stop check and timeout.
  - Outputs: code_valid pulse, code[7:0], frame_err.
- The top module holds the DECODE/WRITE/BKSP FSM and the cursor.

Test Plan:
- Frame 0x1C, odd parity ok, cursor=0 -> one wr_en pulse; wr_addr=0, wr_data=9'h141; cursor=1.
- Sequence 0x1C, 0xF0, 0x1C -> exactly one write; break flag clear afterwards.
- 32 frames of 0x29 -> writes to addresses 0..31 of 9'h120; cursor returns to 0; 33rd write goes to addr 0.
- Backspace:
  - cursor=5, frame 0x66 -> write addr 4, data 9'h120, cursor=4.
  - cursor=0, frame 0x66 -> no write, cursor=0.
- Error frames:
  - Frame 0x1C with parity bit flipped -> frame_err pulse, no write.
  - Frame stopped after 4 bits -> frame_err exactly TIMEOUT_CYCLES after the last edge; next valid frame decodes normally.
- Assert rst during bit 5 of a frame -> all outputs 0 immediately; the remaining bits produce no write; next full frame 0x16 writes 9'h131 at addr 0.
